// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   Parametrised VGA timing and test-pattern generator. A 16-bit phase
//   accumulator derives the pixel strobe from CLK. Horizontal/vertical
//   counters advance on each strobe. Sync, blanking, coordinates and colour
//   are registered on that same strobe edge, so they always describe the
//   same pixel. The pattern is chosen at run time through MODE:
//   colour bars, checkerboard, bouncing square or gradient.
//
// Ports
//   CLK          in   system clock
//   RST_BTN      in   synchronous active-high reset
//   MODE         in   pattern select: 0 bars, 1 checker, 2 square, 3 gradient
//   VGA_HS_OUT   out  horizontal sync (active level HS_POL)
//   VGA_VS_OUT   out  vertical sync (active level VS_POL)
//   VGA_R/G/B    out  colour channels, zero outside the active area
//   O_X, O_Y     out  current pixel coordinates (full raster, incl. blanking)
//   O_ACTIVE     out  pixel lies in the visible area
//   O_PIX_STB    out  one-CLK pulse in the cycle after the outputs update
//   O_FRAME_STB  out  as O_PIX_STB, only for the update that enters (0,0)
module vga_pattern_gen #(
    parameter int          H_ACTIVE = 1024,
    parameter int          H_FP     = 24,
    parameter int          H_SYNC   = 136,
    parameter int          H_BP     = 160,
    parameter int          V_ACTIVE = 768,
    parameter int          V_FP     = 3,
    parameter int          V_SYNC   = 6,
    parameter int          V_BP     = 29,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter logic [15:0] STB_INC  = 16'hA666,
    parameter int          COLOR_W  = 4,
    parameter int          SQ_SIZE  = 64,
    parameter int          SQ_STEP  = 2,
    localparam int         H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int         V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int         X_W      = $clog2(H_TOTAL),
    localparam int         Y_W      = $clog2(V_TOTAL)
) (
    input  logic               CLK,
    input  logic               RST_BTN,
    input  logic [1:0]         MODE,
    output logic               VGA_HS_OUT,
    output logic               VGA_VS_OUT,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B,
    output logic [X_W-1:0]     O_X,
    output logic [Y_W-1:0]     O_Y,
    output logic               O_ACTIVE,
    output logic               O_PIX_STB,
    output logic               O_FRAME_STB
);

    localparam int YA_W     = $clog2(V_ACTIVE);
    localparam int BAR_W    = H_ACTIVE / 8;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [15:0]        r_acc;
    logic               r_stb;
    logic [X_W-1:0]     r_hc;
    logic [Y_W-1:0]     r_vc;
    logic [1:0]         r_mode;
    logic [X_W-1:0]     r_sx;
    logic [Y_W-1:0]     r_sy;
    logic               r_dx;      // 1 = moving towards smaller x
    logic               r_dy;
    logic [7:0]         r_frame;

    logic [X_W-1:0]     w_hc_n;
    logic [Y_W-1:0]     w_vc_n;
    logic               w_sof;
    logic [1:0]         w_mode_n;
    logic [X_W-1:0]     w_sx_n;
    logic [Y_W-1:0]     w_sy_n;
    logic               w_dx_n;
    logic               w_dy_n;
    logic [7:0]         w_frame_n;
    logic               w_active;
    logic               w_hs_act;
    logic               w_vs_act;
    logic [2:0]         w_bar;
    logic               w_in_sq;
    logic [COLOR_W-1:0] w_r;
    logic [COLOR_W-1:0] w_g;
    logic [COLOR_W-1:0] w_b;

    // Post-advance counters: everything below is decoded from the pixel the
    // strobe is about to enter, so coordinates and colour stay aligned.
    always_comb begin
        w_hc_n = r_hc + 1'b1;
        w_vc_n = r_vc;
        if (r_hc == X_W'(H_TOTAL - 1)) begin
            w_hc_n = '0;
            w_vc_n = (r_vc == Y_W'(V_TOTAL - 1)) ? '0 : r_vc + 1'b1;
        end
    end

    assign w_sof     = (w_hc_n == '0) && (w_vc_n == '0);
    assign w_mode_n  = w_sof ? MODE : r_mode;
    assign w_frame_n = w_sof ? r_frame + 8'd1 : r_frame;

    // Square position steps once per frame; the edge test looks one step
    // ahead so the square never leaves the visible area.
    always_comb begin
        w_sx_n = r_sx;
        w_dx_n = r_dx;
        w_sy_n = r_sy;
        w_dy_n = r_dy;
        if (w_sof) begin
            if (!r_dx) begin
                if (32'(r_sx) + 32'(SQ_STEP + SQ_SIZE) > 32'(H_ACTIVE)) begin
                    w_dx_n = 1'b1;
                    w_sx_n = r_sx - X_W'(SQ_STEP);
                end else begin
                    w_sx_n = r_sx + X_W'(SQ_STEP);
                end
            end else begin
                if (32'(r_sx) < 32'(SQ_STEP)) begin
                    w_dx_n = 1'b0;
                    w_sx_n = r_sx + X_W'(SQ_STEP);
                end else begin
                    w_sx_n = r_sx - X_W'(SQ_STEP);
                end
            end
            if (!r_dy) begin
                if (32'(r_sy) + 32'(SQ_STEP + SQ_SIZE) > 32'(V_ACTIVE)) begin
                    w_dy_n = 1'b1;
                    w_sy_n = r_sy - Y_W'(SQ_STEP);
                end else begin
                    w_sy_n = r_sy + Y_W'(SQ_STEP);
                end
            end else begin
                if (32'(r_sy) < 32'(SQ_STEP)) begin
                    w_dy_n = 1'b0;
                    w_sy_n = r_sy + Y_W'(SQ_STEP);
                end else begin
                    w_sy_n = r_sy - Y_W'(SQ_STEP);
                end
            end
        end
    end

    assign w_active = (32'(w_hc_n) < 32'(H_ACTIVE)) && (32'(w_vc_n) < 32'(V_ACTIVE));
    assign w_hs_act = (32'(w_hc_n) >= 32'(HS_START)) && (32'(w_hc_n) < 32'(HS_END));
    assign w_vs_act = (32'(w_vc_n) >= 32'(VS_START)) && (32'(w_vc_n) < 32'(VS_END));
    assign w_bar    = 3'(w_hc_n / X_W'(BAR_W));
    assign w_in_sq  = (w_hc_n >= w_sx_n) && (32'(w_hc_n) < 32'(w_sx_n) + 32'(SQ_SIZE)) &&
                      (w_vc_n >= w_sy_n) && (32'(w_vc_n) < 32'(w_sy_n) + 32'(SQ_SIZE));

    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        case (w_mode_n)
            2'd0: begin
                w_r = {COLOR_W{w_bar[2]}};
                w_g = {COLOR_W{w_bar[1]}};
                w_b = {COLOR_W{w_bar[0]}};
            end
            2'd1: begin
                w_r = {COLOR_W{w_hc_n[5] ^ w_vc_n[5]}};
                w_g = {COLOR_W{w_hc_n[5] ^ w_vc_n[5]}};
                w_b = {COLOR_W{w_hc_n[5] ^ w_vc_n[5]}};
            end
            2'd2: begin
                w_r = {COLOR_W{w_in_sq}};
                w_g = {COLOR_W{w_in_sq}};
                w_b = '1;
            end
            default: begin
                w_r = w_hc_n[X_W-1 -: COLOR_W];
                w_g = w_vc_n[YA_W-1 -: COLOR_W];
                w_b = w_frame_n[COLOR_W-1:0];
            end
        endcase
        if (!w_active) begin
            w_r = '0;
            w_g = '0;
            w_b = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_BTN) begin
            r_acc       <= '0;
            r_stb       <= 1'b0;
            r_hc        <= '0;
            r_vc        <= '0;
            r_mode      <= '0;
            r_sx        <= '0;
            r_sy        <= '0;
            r_dx        <= 1'b0;
            r_dy        <= 1'b0;
            r_frame     <= '0;
            VGA_HS_OUT  <= ~HS_POL;
            VGA_VS_OUT  <= ~VS_POL;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            O_ACTIVE    <= 1'b0;
            O_PIX_STB   <= 1'b0;
            O_FRAME_STB <= 1'b0;
        end else begin
            {r_stb, r_acc} <= {1'b0, r_acc} + {1'b0, STB_INC};
            O_PIX_STB      <= r_stb;
            O_FRAME_STB    <= r_stb & w_sof;
            if (r_stb) begin
                r_hc       <= w_hc_n;
                r_vc       <= w_vc_n;
                r_mode     <= w_mode_n;
                r_sx       <= w_sx_n;
                r_sy       <= w_sy_n;
                r_dx       <= w_dx_n;
                r_dy       <= w_dy_n;
                r_frame    <= w_frame_n;
                VGA_HS_OUT <= w_hs_act ? HS_POL : ~HS_POL;
                VGA_VS_OUT <= w_vs_act ? VS_POL : ~VS_POL;
                VGA_R      <= w_r;
                VGA_G      <= w_g;
                VGA_B      <= w_b;
                O_ACTIVE   <= w_active;
            end
        end
    end

    assign O_X = r_hc;
    assign O_Y = r_vc;

endmodule

// File: tb/tb_vga_pattern_gen.sv
module tb_vga_pattern_gen;

    // Reduced raster so several whole frames fit in a short run.
    localparam int HA = 64, HFP = 4, HSY = 8, HBP = 4;
    localparam int VA = 48, VFP = 2, VSY = 2, VBP = 2;
    localparam int HT = HA + HFP + HSY + HBP;   // 80
    localparam int VT = VA + VFP + VSY + VBP;   // 54
    localparam int XW = $clog2(HT);
    localparam int YW = $clog2(VT);
    localparam int SQ = 40, STEP = 8;
    localparam int BOUND = 12000;

    logic          CLK = 1'b0;
    logic          RST_BTN = 1'b1;
    logic [1:0]    MODE = 2'd0;
    logic          VGA_HS_OUT, VGA_VS_OUT;
    logic [3:0]    VGA_R, VGA_G, VGA_B;
    logic [XW-1:0] O_X;
    logic [YW-1:0] O_Y;
    logic          O_ACTIVE, O_PIX_STB, O_FRAME_STB;

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .STB_INC(16'hA666),
        .COLOR_W(4), .SQ_SIZE(SQ), .SQ_STEP(STEP)
    ) dut (
        .CLK(CLK), .RST_BTN(RST_BTN), .MODE(MODE),
        .VGA_HS_OUT(VGA_HS_OUT), .VGA_VS_OUT(VGA_VS_OUT),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .O_X(O_X), .O_Y(O_Y), .O_ACTIVE(O_ACTIVE),
        .O_PIX_STB(O_PIX_STB), .O_FRAME_STB(O_FRAME_STB)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string    tag;
        int       x;
        int       y;
        logic [3:0] r, g, b;
        logic     hs, vs, act;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   vectors = 0;
    int   miscompares = 0;
    int   stb_cnt = 0;
    bit   stb_done = 1'b0;
    int   fk = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(string tag, int x, int y, logic [3:0] r, logic [3:0] g, logic [3:0] b);
        exp_t e;
        e.tag = tag;
        e.x   = x;
        e.y   = y;
        e.act = (x < HA) && (y < VA);
        e.r   = e.act ? r : 4'h0;
        e.g   = e.act ? g : 4'h0;
        e.b   = e.act ? b : 4'h0;
        e.hs  = !((x >= HA + HFP) && (x < HA + HFP + HSY));
        e.vs  = !((y >= VA + VFP) && (y < VA + VFP + VSY));
        return e;
    endfunction

    // Scoreboard consumer: the head expectation is checked when its pixel is output.
    always @(negedge CLK) begin
        if (O_PIX_STB && q.size() > 0) begin
            if (int'(O_X) == q[0].x && int'(O_Y) == q[0].y) begin
                cur = q.pop_front();
                chk({cur.tag, ".r"}, VGA_R, cur.r);
                chk({cur.tag, ".g"}, VGA_G, cur.g);
                chk({cur.tag, ".b"}, VGA_B, cur.b);
                chk({cur.tag, ".hs"}, VGA_HS_OUT, cur.hs);
                chk({cur.tag, ".vs"}, VGA_VS_OUT, cur.vs);
                chk({cur.tag, ".act"}, O_ACTIVE, cur.act);
            end
        end
    end

    task automatic wait_empty(string tag);
        int n = 0;
        while (q.size() > 0 && n < BOUND) begin
            @(posedge CLK); #1; n++;
        end
        chk({tag, ".pending"}, q.size(), 0);
        q.delete();
    endtask

    task automatic wait_frame(string tag);
        int n = 0;
        do begin
            @(posedge CLK); #1; n++;
        end while (!O_FRAME_STB && n < BOUND);
        fk++;
        chk({tag, ".frame_stb"}, O_FRAME_STB, 1);
        chk({tag, ".x0"}, O_X, 0);
        chk({tag, ".y0"}, O_Y, 0);
    endtask

    // Square position per frame index since reset (SQ=40, STEP=8, 64x48 visible).
    task automatic push_square(int k);
        int sx, sy;
        int tab [6] = '{0, 8, 16, 24, 16, 8};
        sx = tab[k % 6];
        sy = (k % 2 == 1) ? 8 : 0;
        if (sx > 0) q.push_back(mk($sformatf("sq%0d.left", k), sx - 1, sy, 4'h0, 4'h0, 4'hF));
        q.push_back(mk($sformatf("sq%0d.tl", k), sx, sy, 4'hF, 4'hF, 4'hF));
        q.push_back(mk($sformatf("sq%0d.right", k), sx + SQ, sy, 4'h0, 4'h0, 4'hF));
        q.push_back(mk($sformatf("sq%0d.br", k), sx + SQ - 1, sy + SQ - 1, 4'hF, 4'hF, 4'hF));
        q.push_back(mk($sformatf("sq%0d.below", k), sx, sy + SQ, 4'h0, 4'h0, 4'hF));
    endtask

    task automatic measure_line();
        int n, n_stb, hs_lo, n_act, hs_first, act_last;
        n = 0;
        do begin
            @(posedge CLK); #1; n++;
        end while (!(O_PIX_STB && O_X == 0) && n < BOUND);
        n_stb = 0; hs_lo = 0; n_act = 0; hs_first = -1; act_last = -1; n = 0;
        do begin
            if (O_PIX_STB) begin
                n_stb++;
                if (!VGA_HS_OUT) begin
                    hs_lo++;
                    if (hs_first < 0) hs_first = int'(O_X);
                end
                if (O_ACTIVE) begin
                    n_act++;
                    act_last = int'(O_X);
                end
            end
            @(posedge CLK); #1; n++;
        end while (!(O_PIX_STB && O_X == 0) && n < BOUND);
        chk("line.strobes", n_stb, HT);
        chk("line.hs_low", hs_lo, HSY);
        chk("line.hs_first_x", hs_first, HA + HFP);
        chk("line.active_cnt", n_act, HA);
        chk("line.active_last_x", act_last, HA - 1);
    endtask

    task automatic measure_frame();
        int n, n_stb, vs_lo, vs_first;
        n_stb = 0; vs_lo = 0; vs_first = -1; n = 0;
        do begin
            if (O_PIX_STB) begin
                n_stb++;
                if (!VGA_VS_OUT) begin
                    vs_lo++;
                    if (vs_first < 0) vs_first = int'(O_Y);
                end
            end
            @(posedge CLK); #1; n++;
        end while (!O_FRAME_STB && n < 3 * BOUND);
        fk++;
        chk("frame.strobes", n_stb, HT * VT);
        chk("frame.vs_low", vs_lo, VSY * HT);
        chk("frame.vs_first_y", vs_first, VA + VFP);
    endtask

    initial begin
        int n;

        // Mid-frame reset
        repeat (3) @(posedge CLK);
        @(negedge CLK) RST_BTN = 1'b0;
        repeat (500) @(posedge CLK);
        @(negedge CLK) RST_BTN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst.x", O_X, 0);
        chk("rst.y", O_Y, 0);
        chk("rst.hs", VGA_HS_OUT, 1);
        chk("rst.vs", VGA_VS_OUT, 1);
        chk("rst.r", VGA_R, 0);
        chk("rst.g", VGA_G, 0);
        chk("rst.b", VGA_B, 0);
        chk("rst.active", O_ACTIVE, 0);
        chk("rst.pix_stb", O_PIX_STB, 0);
        chk("rst.frame_stb", O_FRAME_STB, 0);

        @(negedge CLK) RST_BTN = 1'b0;
        fork
            begin
                @(posedge CLK);
                for (int i = 0; i < 65536; i++) begin
                    @(posedge CLK); #1;
                    if (O_PIX_STB) stb_cnt++;
                end
                stb_done = 1'b1;
            end
        join_none

        // First strobe: carry appears on edge 2, outputs on edge 3, at (1,0)
        n = 0;
        do begin
            @(posedge CLK); #1; n++;
        end while (!O_PIX_STB && n < 10);
        chk("first_stb.clks", n, 3);
        chk("first_stb.x", O_X, 1);
        chk("first_stb.y", O_Y, 0);

        // Bars (mode 0 since reset), row 5 of frame 0
        q.push_back(mk("bars.x0", 0, 5, 4'h0, 4'h0, 4'h0));
        q.push_back(mk("bars.x8", 8, 5, 4'h0, 4'h0, 4'hF));
        q.push_back(mk("bars.x63", 63, 5, 4'hF, 4'hF, 4'hF));
        q.push_back(mk("bars.x64", 64, 5, 4'h0, 4'h0, 4'h0));
        wait_empty("bars");

        measure_line();

        // Bouncing square for frames 1..4, including the right-edge flip
        MODE = 2'd2;
        wait_frame("f1");
        push_square(1);
        measure_frame();
        chk("f2.x0", O_X, 0);
        chk("f2.y0", O_Y, 0);
        push_square(2);
        wait_frame("f3");
        push_square(3);
        wait_frame("f4");
        push_square(4);
        wait_empty("square");

        // Mode latch: switch bars -> checker mid-frame
        MODE = 2'd0;
        wait_frame("f5");
        n = 0;
        do begin
            @(posedge CLK); #1; n++;
        end while (O_Y != 24 && n < BOUND);
        chk("latch.reach_y24", O_Y, 24);
        MODE = 2'd1;
        q.push_back(mk("latch.still_bars", 32, 30, 4'hF, 4'h0, 4'h0));
        q.push_back(mk("chk.x0y0", 0, 0, 4'h0, 4'h0, 4'h0));
        q.push_back(mk("chk.x32y0", 32, 0, 4'hF, 4'hF, 4'hF));
        q.push_back(mk("chk.x0y32", 0, 32, 4'hF, 4'hF, 4'hF));
        q.push_back(mk("chk.x32y32", 32, 32, 4'h0, 4'h0, 4'h0));
        wait_frame("f6");
        wait_empty("latch");

        // Gradient in frame 7
        MODE = 2'd3;
        wait_frame("f7");
        q.push_back(mk("grad.x40y20", 40, 20, 4'd5, 4'd5, 4'(fk)));
        q.push_back(mk("grad.x70y20", 70, 20, 4'h0, 4'h0, 4'h0));
        q.push_back(mk("grad.x8y47", 8, 47, 4'd1, 4'd11, 4'(fk)));
        wait_empty("grad");

        wait (stb_done);
        chk("stb_rate", stb_cnt, 42598);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
